hci_mem_responder: RTL and testbench

HCI_MEM_RESPONDER -- requirements
Module: hci_mem_responder

---
 rtl/hci_package.sv | 14 +
 rtl/hci_mem_intf.sv | 32 +++
 rtl/hci_mem_resp_pipe.sv | 61 ++++++
 rtl/hci_mem_responder.sv | 127 ++++++++++++
 tb/tb_hci_mem_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/hci_package.sv
// Shared types and constants for the HCI memory-side blocks.
package hci_package;

  localparam int unsigned DEFAULT_AW           = 32;
  localparam int unsigned DEFAULT_DW           = 32;
  localparam int unsigned DEFAULT_UW           = 1;
  localparam int unsigned HCI_MEM_RESP_MAX_LAT = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    TS_WRITE = 1'b1
  } hci_mem_resp_state_t;

endpackage

// File: rtl/hci_mem_intf.sv
// TCDM-style request/response bundle between an initiator and a memory bank.
interface hci_mem_intf #(
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned DW = hci_package::DEFAULT_DW,
  parameter int unsigned IW = 8,
  parameter int unsigned UW = hci_package::DEFAULT_UW
) ();

  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic [IW-1:0]   id;
  logic [UW-1:0]   user;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic [IW-1:0]   r_id;
  logic [UW-1:0]   r_user;

  modport master (
    output req, add, wen, be, data, id, user,
    input  gnt, r_data, r_valid, r_id, r_user
  );

  modport slave (
    input  req, add, wen, be, data, id, user,
    output gnt, r_data, r_valid, r_id, r_user
  );

endinterface

// File: rtl/hci_mem_resp_pipe.sv
// Fixed-depth response delay line; payload is zeroed in any stage that is not valid.
module hci_mem_resp_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DW      = 32,
  parameter int unsigned IW      = 8,
  parameter int unsigned UW      = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [IW-1:0] in_id,
  input  logic [UW-1:0] in_user,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_id,
  output logic [UW-1:0] out_user
);

  logic [LATENCY-1:0] valid_r;
  logic [DW-1:0]      data_r [LATENCY];
  logic [IW-1:0]      id_r   [LATENCY];
  logic [UW-1:0]      user_r [LATENCY];

  // Shift register of response stages, flushed by reset or clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= '0;
        id_r[i]    <= '0;
        user_r[i]  <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= '0;
        id_r[i]    <= '0;
        user_r[i]  <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_valid ? in_data : '0;
      id_r[0]    <= in_valid ? in_id   : '0;
      user_r[0]  <= in_valid ? in_user : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
        id_r[i]    <= id_r[i-1];
        user_r[i]  <= user_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LATENCY-1];
  assign out_data  = data_r[LATENCY-1];
  assign out_id    = id_r[LATENCY-1];
  assign out_user  = user_r[LATENCY-1];

endmodule

// File: rtl/hci_mem_responder.sv
// Behavioural single-bank TCDM responder with fixed read latency, grant throttling
// and a test-and-set side effect on reads that carry the TS address bit.
module hci_mem_responder
  import hci_package::*;
#(
  parameter int unsigned N_WORDS = 1024,
  parameter int unsigned AW      = DEFAULT_AW,
  parameter int unsigned DW      = DEFAULT_DW,
  parameter int unsigned IW      = 8,
  parameter int unsigned UW      = DEFAULT_UW,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TS_BIT  = 21
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic [7:0] stall_period_i,
  hci_mem_intf.slave tcdm
);

  localparam int unsigned IDX_W = $clog2(N_WORDS);
  localparam int unsigned BW    = DW / 8;

  logic [DW-1:0]       mem [N_WORDS];
  logic [IDX_W-1:0]    idx_s;
  logic [IDX_W-1:0]    ts_idx_r;
  hci_mem_resp_state_t state_r;
  hci_mem_resp_state_t state_next_s;
  logic [7:0]          cnt_r;
  logic [7:0]          cnt_next_s;
  logic                throttle_s;
  logic                gnt_s;
  logic                hs_s;
  logic                ts_wr_s;
  logic [DW-1:0]       rdata_s;
  logic                unused_s;

  assign idx_s      = tcdm.add[2 +: IDX_W];
  assign throttle_s = (stall_period_i != 8'd0) && (cnt_r == stall_period_i - 8'd1);
  assign hs_s       = tcdm.req && gnt_s;
  assign tcdm.gnt   = gnt_s;
  assign unused_s   = ^tcdm.add;

  // Grant and test-and-set sequencing; clear blocks the grant and so any TS entry.
  always_comb begin
    state_next_s = state_r;
    gnt_s        = 1'b0;
    ts_wr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        gnt_s = tcdm.req && !clear_i && !throttle_s;
        if (gnt_s && tcdm.wen && tcdm.add[TS_BIT]) begin
          state_next_s = TS_WRITE;
        end else begin
          state_next_s = IDLE;
        end
      end
      TS_WRITE: begin
        ts_wr_s      = !clear_i;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Throttle counter; a period shrunk below the current count wraps immediately.
  always_comb begin
    cnt_next_s = 8'd0;
    if (clear_i || (stall_period_i == 8'd0)) begin
      cnt_next_s = 8'd0;
    end else if (cnt_r >= stall_period_i - 8'd1) begin
      cnt_next_s = 8'd0;
    end else begin
      cnt_next_s = cnt_r + 8'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      ts_idx_r <= '0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      ts_idx_r <= hs_s ? idx_s : ts_idx_r;
    end
  end

  // Storage array; intentionally not reset so contents survive rst_ni and clear_i.
  always_ff @(posedge clk_i) begin
    if (ts_wr_s) begin
      mem[ts_idx_r] <= '1;
    end else if (hs_s && !tcdm.wen) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (tcdm.be[b]) begin
          mem[idx_s][8*b +: 8] <= tcdm.data[8*b +: 8];
        end
      end
    end
  end

  assign rdata_s = (hs_s && tcdm.wen) ? mem[idx_s] : '0;

  hci_mem_resp_pipe #(
    .LATENCY (LATENCY),
    .DW      (DW),
    .IW      (IW),
    .UW      (UW)
  ) u_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .in_valid  (hs_s),
    .in_data   (rdata_s),
    .in_id     (tcdm.id),
    .in_user   (tcdm.user),
    .out_valid (tcdm.r_valid),
    .out_data  (tcdm.r_data),
    .out_id    (tcdm.r_id),
    .out_user  (tcdm.r_user)
  );

endmodule

// File: tb/tb_hci_mem_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) share one stimulus stream and one reference model.
module tb_hci_mem_responder;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [7:0]  id;
    logic        u;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  stall_period = 8'd0;
  logic        req = 1'b0;
  logic        wen = 1'b1;
  logic [31:0] add = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [31:0] data = 32'h0;
  logic [7:0]  id = 8'h0;
  logic        user = 1'b0;

  logic        rst_next = 1'b0;
  logic [7:0]  per_next = 8'd0;
  int          cyc = 0;
  logic        exp_gnt = 1'b0;
  logic        win = 1'b0;
  int          gcount = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  resp_t       q1[$];
  resp_t       q3[$];
  logic [31:0] mmem [32];
  int          m_cnt = 0;
  logic        m_ts = 1'b0;
  logic [4:0]  m_ts_idx = 5'd0;

  hci_mem_intf #(.AW(32), .DW(32), .IW(8), .UW(1)) if1 ();
  hci_mem_intf #(.AW(32), .DW(32), .IW(8), .UW(1)) if3 ();

  assign if1.req = req;  assign if1.wen = wen;  assign if1.add = add;  assign if1.be = be;
  assign if1.data = data; assign if1.id = id;   assign if1.user = user;
  assign if3.req = req;  assign if3.wen = wen;  assign if3.add = add;  assign if3.be = be;
  assign if3.data = data; assign if3.id = id;   assign if3.user = user;

  hci_mem_responder #(.N_WORDS(32), .AW(32), .DW(32), .IW(8), .UW(1), .LATENCY(1), .TS_BIT(21)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_period_i(stall_period), .tcdm(if1)
  );

  hci_mem_responder #(.N_WORDS(32), .AW(32), .DW(32), .IW(8), .UW(1), .LATENCY(3), .TS_BIT(21)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .stall_period_i(stall_period), .tcdm(if3)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive inputs after the edge, then advance the reference model.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [7:0] i, input logic u, input logic clr);
    logic       thr;
    logic       eg;
    logic       ts_nx;
    logic [4:0] ix;
    resp_t      e;
    @(posedge clk); #1;
    rst_n = rst_next; stall_period = per_next; clear = clr;
    req = r; wen = w; add = a; be = b; data = d; id = i; user = u;
    cyc++;
    if (!rst_n) begin
      q1.delete(); q3.delete(); m_cnt = 0; m_ts = 1'b0;
    end
    thr = (stall_period != 8'd0) && (m_cnt == int'(stall_period) - 1);
    eg = r && !clr && !m_ts && !thr;
    exp_gnt = eg;
    ts_nx = 1'b0;
    if (m_ts && !clr) mmem[m_ts_idx] = 32'hFFFF_FFFF;
    if (eg) begin
      ix = a[6:2];
      e.id = i; e.u = u; e.due = cyc + 1;
      if (w) begin
        e.data = mmem[ix];
        ts_nx = a[21];
        m_ts_idx = ix;
      end else begin
        e.data = 32'h0;
        for (int k = 0; k < 4; k++) if (b[k]) mmem[ix][8*k +: 8] = d[8*k +: 8];
      end
      q1.push_back(e);
      e.due = cyc + 3;
      q3.push_back(e);
    end
    m_ts = ts_nx;
    if (clr || stall_period == 8'd0 || m_cnt >= int'(stall_period) - 1) m_cnt = 0;
    else m_cnt++;
    if (clr) begin
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
      while (q3.size() > 0 && q3[$].due > cyc) void'(q3.pop_back());
    end
    if (!rst_n) begin
      m_cnt = 0; m_ts = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input logic [7:0] i);
    step(1'b1, 1'b0, a, b, d, i, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] i);
    step(1'b1, 1'b1, a, 4'h0, 32'h0, i, 1'b1, 1'b0);
  endtask

  task automatic idle(input logic clr);
    step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 8'h0, 1'b0, clr);
  endtask

  task automatic chk(input string nm, input logic v, input logic [31:0] dt, input logic [7:0] ri,
                     input logic ru, input bit h, input resp_t e);
    n_tests++;
    if (h) begin
      if (v !== 1'b1 || dt !== e.data || ri !== e.id || ru !== e.u) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got v=%b d=%h id=%h u=%b exp v=1 d=%h id=%h u=%b",
                 nm, cyc, v, dt, ri, ru, e.data, e.id, e.u);
      end
    end else if (v !== 1'b0 || dt !== 32'h0 || ri !== 8'h0 || ru !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got v=%b d=%h id=%h u=%b exp all zero", nm, cyc, v, dt, ri, ru);
    end
  endtask

  resp_t e1;
  resp_t e3;
  bit    h1;
  bit    h3;

  // Monitor: grant check and in-order response check for both latencies.
  always @(negedge clk) begin
    if (cyc > 0) begin
      n_tests++;
      if (if1.gnt !== exp_gnt || if3.gnt !== exp_gnt) begin
        n_fail++;
        $display("FAIL gnt cyc=%0d got %b/%b exp %b", cyc, if1.gnt, if3.gnt, exp_gnt);
      end
      if (win && if1.gnt === 1'b1) gcount++;
      h1 = (q1.size() > 0) && (q1[0].due == cyc);
      e1 = h1 ? q1.pop_front() : '{0, 32'h0, 8'h0, 1'b0};
      h3 = (q3.size() > 0) && (q3[0].due == cyc);
      e3 = h3 ? q3.pop_front() : '{0, 32'h0, 8'h0, 1'b0};
      chk("resp_lat1", if1.r_valid, if1.r_data, if1.r_id, if1.r_user, h1, e1);
      chk("resp_lat3", if3.r_valid, if3.r_data, if3.r_id, if3.r_user, h3, e3);
    end
  end

  logic [31:0] ra;

  initial begin
    idle(1'b0); idle(1'b0);
    rst_next = 1'b1;
    idle(1'b0);
    for (int k = 0; k < 32; k++) wr(32'(k * 4), $urandom, 4'hF, 8'(k));

    wr(32'h10, 32'hDEAD_BEEF, 4'hF, 8'd5);
    rd(32'h10, 8'd6);
    idle(1'b0); idle(1'b0);

    wr(32'h20, 32'hFFFF_FFFF, 4'hF, 8'd7);
    wr(32'h20, 32'h0000_AB00, 4'b0010, 8'd8);
    rd(32'h20, 8'd9);

    wr(32'h0, 32'h0, 4'hF, 8'd10);
    rd(32'h0020_0000, 8'd11);
    rd(32'h4, 8'd12);
    rd(32'h0, 8'd13);
    idle(1'b0); idle(1'b0); idle(1'b0);

    per_next = 8'd4;
    for (int k = 0; k < 16; k++) begin
      rd(32'(k * 4), 8'(k));
      win = 1'b1;
    end
    idle(1'b0);
    win = 1'b0;
    n_tests++;
    if (gcount != 12) begin
      n_fail++;
      $display("FAIL throttle_grants got %0d exp 12", gcount);
    end

    per_next = 8'd8;
    for (int k = 0; k < 6; k++) idle(1'b0);
    per_next = 8'd2;
    for (int k = 0; k < 5; k++) rd(32'h8, 8'(20 + k));
    per_next = 8'd1;
    for (int k = 0; k < 3; k++) rd(32'h8, 8'(30 + k));
    per_next = 8'd0;
    idle(1'b0); idle(1'b0); idle(1'b0);

    rd(32'h40, 8'd40); rd(32'h44, 8'd41); rd(32'h48, 8'd42);
    step(1'b1, 1'b1, 32'h4C, 4'h0, 32'h0, 8'd43, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) idle(1'b0);
    rd(32'h40, 8'd44); rd(32'h44, 8'd45); rd(32'h48, 8'd46);
    rd(32'h0020_004C, 8'd47);
    idle(1'b1);
    idle(1'b0);
    rd(32'h4C, 8'd48);
    idle(1'b0); idle(1'b0); idle(1'b0);

    rd(32'h50, 8'd50); rd(32'h54, 8'd51);
    rst_next = 1'b0;
    idle(1'b0);
    rst_next = 1'b1;
    for (int k = 0; k < 4; k++) idle(1'b0);

    for (int k = 0; k < 400; k++) begin
      ra = $urandom;
      if ($urandom_range(0, 9) != 0) ra[21] = 1'b0;
      if ($urandom_range(0, 49) == 0) per_next = 8'($urandom_range(0, 5));
      step(1'($urandom_range(0, 9) < 7), 1'($urandom), ra, 4'($urandom), $urandom,
           8'($urandom), 1'($urandom), 1'($urandom_range(0, 29) == 0));
    end
    per_next = 8'd0;
    for (int k = 0; k < 6; k++) idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
